// File: rtl/lives_controller.sv
`default_nettype none
// ============================================================================
//  Module      : lives_controller
//  Description : Two-player lives bookkeeping with per-player invulnerability
//                cooldown and the match state machine (idle/play/over) with
//                winner reporting. Every output is driven from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module lives_controller #(
    parameter int START_LIVES = 3,
    parameter int COOLDOWN    = 25_000_000,
    parameter int CD_W        = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit1,
    input  logic       hit2,
    output logic [1:0] lives1,
    output logic [1:0] lives2,
    output logic       playing,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       invuln1,
    output logic       invuln2
);

    localparam logic [1:0]      C_START = 2'(START_LIVES);
    localparam logic [CD_W-1:0] C_COOL  = CD_W'(COOLDOWN);
    localparam logic [CD_W-1:0] C_ONE   = CD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [1:0]      lives1_q,  lives1_d;
    logic [1:0]      lives2_q,  lives2_d;
    logic [CD_W-1:0] cd1_q,     cd1_d;
    logic [CD_W-1:0] cd2_q,     cd2_d;
    logic [1:0]      winner_q,  winner_d;
    logic            playing_q, playing_d;
    logic            over_q,    over_d;
    logic            inv1_q,    inv1_d;
    logic            inv2_q,    inv2_d;

    // A hit counts only while that player is vulnerable and still alive.
    logic hit1_ok;
    logic hit2_ok;
    assign hit1_ok = hit1 && (cd1_q == '0) && (lives1_q != 2'd0);
    assign hit2_ok = hit2 && (cd2_q == '0) && (lives2_q != 2'd0);

    // State, lives, cooldown and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lives1_q  <= C_START;
            lives2_q  <= C_START;
            cd1_q     <= '0;
            cd2_q     <= '0;
            winner_q  <= 2'b00;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            inv1_q    <= 1'b0;
            inv2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives1_q  <= lives1_d;
            lives2_q  <= lives2_d;
            cd1_q     <= cd1_d;
            cd2_q     <= cd2_d;
            winner_q  <= winner_d;
            playing_q <= playing_d;
            over_q    <= over_d;
            inv1_q    <= inv1_d;
            inv2_q    <= inv2_d;
        end
    end

    // Next-state logic: cooldowns free-run down, hits only matter in PLAY,
    // and the end-of-match decision looks at the post-hit lives values.
    always_comb begin
        state_d  = state_q;
        lives1_d = lives1_q;
        lives2_d = lives2_q;
        winner_d = winner_q;
        cd1_d    = (cd1_q != '0) ? (cd1_q - C_ONE) : cd1_q;
        cd2_d    = (cd2_q != '0) ? (cd2_q - C_ONE) : cd2_q;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_PLAY;
                    lives1_d = C_START;
                    lives2_d = C_START;
                    cd1_d    = '0;
                    cd2_d    = '0;
                    winner_d = 2'b00;
                end
            end
            ST_PLAY: begin
                if (hit1_ok) begin
                    lives1_d = lives1_q - 2'd1;
                    cd1_d    = C_COOL;
                end
                if (hit2_ok) begin
                    lives2_d = lives2_q - 2'd1;
                    cd2_d    = C_COOL;
                end
                if ((lives1_d == 2'd0) || (lives2_d == 2'd0)) begin
                    state_d  = ST_OVER;
                    // Bit 1: player 2 won (player 1 out); bit 0: the reverse.
                    winner_d = {lives1_d == 2'd0, lives2_d == 2'd0};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        playing_d = (state_d == ST_PLAY);
        over_d    = (state_d == ST_OVER);
        inv1_d    = (cd1_d != '0);
        inv2_d    = (cd2_d != '0);
    end

    assign lives1    = lives1_q;
    assign lives2    = lives2_q;
    assign playing   = playing_q;
    assign game_over = over_q;
    assign winner    = winner_q;
    assign invuln1   = inv1_q;
    assign invuln2   = inv2_q;

endmodule
`default_nettype wire

// File: doc/lives_controller.md
# lives_controller

Per-player lives bookkeeping and match sequencing for the two-player fighting game. Accepts single-cycle hit pulses from the combat logic, applies a per-player invulnerability window, decrements the 2-bit life counts that feed the seven-segment lives display, and runs the match state machine (idle, playing, game over) with winner reporting. All outputs are registered and are meant to drive the display multiplexer's `lives1`/`lives2` inputs and the game/sprite logic directly.

## Interface
- `START_LIVES`, default 3: lives loaded at reset and at every match start. Legal range 1..3.
- `COOLDOWN`, default 25_000_000: invulnerability length in clk cycles after an accepted hit. Must be ≥1.
- `CD_W`, default 25: cooldown counter width. Must satisfy 2^CD_W > COOLDOWN.
- `clk` input, 1 bit: system clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: single-cycle request to begin a match.
- `hit1` input, 1 bit: single-cycle pulse meaning player 1 was struck.
- `hit2` input, 1 bit: single-cycle pulse meaning player 2 was struck.
- `lives1` output, 2 bits: player 1 remaining lives.
- `lives2` output, 2 bits: player 2 remaining lives.
- `playing` output, 1 bit: high while the FSM is in PLAY.
- `game_over` output, 1 bit: high while the FSM is in OVER.
- `winner` output, 2 bits: 00 none, 01 player 1, 10 player 2, 11 draw. Valid only in OVER.
- `invuln1` output, 1 bit: player 1 cooldown counter nonzero. Used for sprite blinking.
- `invuln2` output, 1 bit: player 2 cooldown counter nonzero.

## Operation
- FSM states: IDLE, PLAY, OVER. Two-bit state register.
- Reset (async, `rst_n`=0) sets state to IDLE, `lives1`=`lives2`=START_LIVES, both cooldown counters to 0, `playing`=0, `game_over`=0, `winner`=00, and `invuln1`=`invuln2`=0.
- IDLE, with `start`=1: move to PLAY, reload both lives to START_LIVES, clear cooldowns. Hits are ignored.
- PLAY, with `start`=1: ignored.
- PLAY, `hitN`=1 while cooldown N is 0 and `livesN`>0: the hit is accepted. `livesN` decrements by 1 and cooldown N loads COOLDOWN.
- PLAY, `hitN`=1 while cooldown N is nonzero: the hit is dropped with no effect.
- Cooldown counters decrement by 1 per cycle while nonzero, in any state. A load has priority over a decrement.
- Simultaneous `hit1` and `hit2`: each is evaluated independently, so both can be accepted in the same cycle.
- PLAY to OVER happens on the same edge that writes a 0 into either lives count. The decision uses the next-state lives values.
  - Only `lives2` becomes 0: `winner`=01.
  - Only `lives1` becomes 0: `winner`=10.
  - Both become 0 on the same edge: `winner`=11.
- OVER: hits are ignored. Lives hold their final values. Cooldowns run down to 0.
- OVER, with `start`=1: move to PLAY, reload lives to START_LIVES, clear cooldowns, set `winner`=00.
- A hit arriving in the same cycle as an accepted `start` is ignored.
- Lives never underflow below 0 and never exceed START_LIVES.

## Timing
- A hit accepted in cycle N updates `livesN`, `invulnN`, `game_over` and `winner` at edge N+1. Latency is 1 cycle.
- After a hit accepted in cycle N, hits in cycles N+1 through N+COOLDOWN are dropped. A hit in cycle N+COOLDOWN+1 is accepted.
- `invulnN` is high from edge N+1 through cycle N+COOLDOWN. It is low at cycle N+COOLDOWN+1.
- `start` in cycle S: `playing`=1 from edge S+1. On restart from OVER, `game_over`=0 and `winner`=00 from edge S+1.
- `playing` and `game_over` are never high together. Both are low only in IDLE.
- Asserting `rst_n` mid-match returns every output to its reset value immediately, with no clock needed.

## Test plan
Bench parameters: START_LIVES=3, COOLDOWN=4, CD_W=3.
- Reset, then `start` pulse at cycle 0, then `hit1` at cycle 3. Required: `playing`=1 at cycle 1; `lives1`=2 and `invuln1`=1 at cycle 4; `lives2`=3.
- `hit1` accepted at cycle 10, then `hit1` at cycles 12 and 14, then `hit1` at cycle 15. Required: 12 and 14 dropped; `lives1` goes 3→2 at cycle 11 and 2→1 at cycle 16; `invuln1`=0 at cycle 15.
- Three spaced `hit2` pulses. Required: after the third, `lives2`=0, `game_over`=1, `playing`=0, `winner`=01 on the same edge. A further `hit1` leaves `lives1` unchanged.
- Both players at 1 life, cooldowns clear, `hit1` and `hit2` asserted in the same cycle. Required: both lives become 0 and `winner`=11.
- In OVER, `start` and `hit1` asserted in the same cycle. Required next cycle: `lives1`=`lives2`=3, `winner`=00, `playing`=1, `invuln1`=0.
- Drop `rst_n` while in PLAY with `lives1`=1 and `invuln2`=1, with no clock edge. Required: immediately `lives1`=`lives2`=3, `invuln2`=0, `playing`=0, and state IDLE.
